// File: rtl/comp_seq.sv
// comp_seq: sequential MSB-first digit-serial magnitude comparator with
// start/busy/done handshake and registered lt/gr/eq flags.
module comp_seq #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             gr,
   output logic             eq
);
   localparam int ND = WIDTH / DIGIT;
   localparam int CW = $clog2(ND + 1);
   typedef enum logic {IDLE, SCAN} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_a, r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_sm, r_dec, r_lt, r_gr;
   logic [DIGIT-1:0] w_da, w_db;
   logic             w_flip, w_dec, w_lt, w_gr;
   // Signed compare flips the sign bits of the leading digit (offset binary)
   always_comb begin
      w_flip = r_sm && (r_cnt == CW'(ND));
      w_da = r_a[WIDTH-1 -: DIGIT];
      w_db = r_b[WIDTH-1 -: DIGIT];
      w_da[DIGIT-1] = r_a[WIDTH-1] ^ w_flip;
      w_db[DIGIT-1] = r_b[WIDTH-1] ^ w_flip;
      w_dec = r_dec || (w_da != w_db);
      w_lt = r_dec ? r_lt : (w_da < w_db);
      w_gr = r_dec ? r_gr : (w_da > w_db);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a <= '0;
         r_b <= '0;
         r_cnt <= '0;
         r_sm <= 1'b0;
         r_dec <= 1'b0;
         r_lt <= 1'b0;
         r_gr <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         lt <= 1'b0;
         gr <= 1'b0;
         eq <= 1'b0;
      end else begin
         done <= 1'b0;
         if (r_state == IDLE) begin
            if (start) begin
               r_a <= a;
               r_b <= b;
               r_sm <= signed_mode;
               r_cnt <= CW'(ND);
               r_dec <= 1'b0;
               r_lt <= 1'b0;
               r_gr <= 1'b0;
               busy <= 1'b1;
               r_state <= SCAN;
            end
         end else begin
            r_a <= r_a << DIGIT;
            r_b <= r_b << DIGIT;
            r_cnt <= r_cnt - CW'(1);
            r_dec <= w_dec;
            r_lt <= w_lt;
            r_gr <= w_gr;
            if (r_cnt == CW'(1)) begin
               lt <= w_lt;
               gr <= w_gr;
               eq <= !w_dec;
               done <= 1'b1;
               busy <= 1'b0;
               r_state <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_comp_seq.sv
// tb_comp_seq: scoreboard bench for comp_seq, 16/4 plus exhaustive 4/1 and 4/2.
module tb_comp_seq;
   logic clk = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_fin = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : G
      localparam int W = (g == 0) ? 16 : 4;
      localparam int D = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
      localparam int N = W / D;
      typedef struct packed {logic l; logic r; logic e; logic [31:0] t;} exp_t;
      logic         rst_n, start, sm, busy, done, lt, gr, eq;
      logic [W-1:0] a, b;
      logic [2:0]   prev;
      exp_t         q[$];

      comp_seq #(.WIDTH(W), .DIGIT(D)) dut (
         .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
         .a(a), .b(b), .busy(busy), .done(done), .lt(lt), .gr(gr), .eq(eq)
      );

      task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
         int   k = 0;
         exp_t e;
         while (busy && k < 100) begin
            @(posedge clk); #1; k++;
         end
         if (busy) chk("issue_wait_busy", 1, 0);
         start = 1'b1; a = x; b = y; sm = s;
         @(posedge clk); #1;
         start = 1'b0;
         e.l = s ? ($signed(x) < $signed(y)) : (x < y);
         e.r = s ? ($signed(x) > $signed(y)) : (x > y);
         e.e = (x == y);
         e.t = 32'(cyc + N);
         q.push_back(e);
      endtask

      task automatic drain();
         int k = 0;
         while (q.size() != 0 && k < 200) begin
            @(posedge clk); #1; k++;
         end
         chk("drain_pending", 64'(q.size()), 0);
      endtask

      always @(negedge clk) begin
         exp_t e;
         if (rst_n) begin
            chk("busy_done_excl", {63'b0, busy & done}, 0);
            if (done) begin
               if (q.size() == 0) chk("spurious_done", 1, 0);
               else begin
                  e = q.pop_front();
                  chk("flags_lt_gr_eq", {61'b0, lt, gr, eq}, {61'b0, e.l, e.r, e.e});
                  chk("latency", 64'(cyc), 64'(e.t));
               end
            end else begin
               chk("flags_stable", {61'b0, lt, gr, eq}, {61'b0, prev});
               if (q.size() != 0) chk("busy_in_scan", {63'b0, busy}, 1);
            end
         end
         prev <= {lt, gr, eq};
      end

      initial begin
         rst_n = 1'b0; start = 1'b0; sm = 1'b0; a = '0; b = '0;
         repeat (3) @(posedge clk);
         #1;
         chk("reset_outputs", {59'b0, busy, done, lt, gr, eq}, 0);
         rst_n = 1'b1;
         @(posedge clk); #1;
      end

      if (g == 0) begin : DIR
         initial begin
            logic [W-1:0] x, y;
            logic [W-1:0] kv;
            #40;
            @(posedge clk); #1;
            issue(16'd5, 16'd7, 1'b0);
            issue(16'hA000, 16'h7FFF, 1'b0);
            issue(16'hA000, 16'h7FFF, 1'b1);
            issue(16'hFFFF, 16'h0000, 1'b1);
            issue(16'h1234, 16'h1234, 1'b0);
            issue(16'h1234, 16'h1234, 1'b1);
            issue(16'h1235, 16'h1234, 1'b0);
            issue(16'd1, 16'd2, 1'b0);
            start = 1'b1; a = 16'd9; b = 16'd3;
            repeat (2) begin
               @(posedge clk); #1;
            end
            start = 1'b0;
            issue(16'd10, 16'd7, 1'b0);
            drain();
            start = 1'b1; a = 16'd3; b = 16'd4; sm = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            chk("reset_abort", {59'b0, busy, done, lt, gr, eq}, 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (10) begin
               @(posedge clk); #1;
            end
            chk("no_done_after_reset", {63'b0, done}, 0);
            for (int i = 0; i < 200; i++) begin
               x = W'($urandom);
               kv = W'($urandom_range(0, 2));
               y = (kv == 0) ? W'($urandom) : (kv == 1) ? x : x ^ W'($urandom_range(1, 15));
               issue(x, y, 1'($urandom));
            end
            drain();
            n_fin++;
         end
      end else begin : EXH
         initial begin
            #40;
            @(posedge clk); #1;
            for (int s = 0; s < 2; s++)
               for (int x = 0; x < 16; x++)
                  for (int y = 0; y < 16; y++)
                     issue(W'(x), W'(y), 1'(s));
            drain();
            n_fin++;
         end
      end
   end

   initial begin
      wait (n_fin == 3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
